// File: rtl/core_seq.sv
// core_seq: instruction sequencer that runs one full compute tile on its own.
// Phases: fetch weights into L0, push them into the PE array, fetch activations,
// execute, then drain OFIFO result rows into PMEM. Every output is registered.
module core_seq #(
   parameter int row     = 8,
   parameter int col     = 8,
   parameter int xmem_aw = 8,
   parameter int pmem_aw = 9,
   parameter int len_w   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               mode_i,
   input  logic [xmem_aw-1:0] w_base,
   input  logic [xmem_aw-1:0] x_base,
   input  logic [len_w-1:0]   x_len,
   input  logic [pmem_aw-1:0] p_base,
   input  logic               l0_ready,
   input  logic               ofifo_valid,
   output logic               xmem_cen,
   output logic [xmem_aw-1:0] xmem_a,
   output logic               l0_wr,
   output logic               l0_rd,
   output logic               load,
   output logic               execute,
   output logic               mode,
   output logic               ofifo_rd,
   output logic               pmem_cen,
   output logic               pmem_wen,
   output logic [pmem_aw-1:0] pmem_a,
   output logic               busy,
   output logic               done
);

   // Phase counters must hold either array dimension or the activation count.
   localparam int row_w = $clog2(row + 1);
   localparam int col_w = $clog2(col + 1);
   localparam int dim_w = (row_w > col_w) ? row_w : col_w;
   localparam int cnt_w = (len_w > dim_w) ? len_w : dim_w;
   localparam logic [cnt_w-1:0] row_c = cnt_w'(row);

   typedef enum logic [2:0] {
      IDLE, WFETCH, WPUSH, XFETCH, EXEC, DRAIN, FIN
   } state_t;

   state_t state, state_n;

   // rd_cnt: requests issued (fetch/drain) or strobe cycles (push/exec).
   // wr_cnt: L0 writes completed (fetch) or PMEM writes issued (drain).
   logic [cnt_w-1:0]   rd_cnt, rd_cnt_n, wr_cnt, wr_cnt_n;
   logic [xmem_aw-1:0] w_base_q, w_base_n, x_base_q, x_base_n;
   logic [len_w-1:0]   x_len_q, x_len_n;
   logic [pmem_aw-1:0] p_base_q, p_base_n;

   logic               xmem_cen_n, l0_wr_n, l0_rd_n, load_n, execute_n, mode_n;
   logic               ofifo_rd_n, pmem_cen_n, pmem_wen_n, busy_n, done_n;
   logic [xmem_aw-1:0] xmem_a_n;
   logic [pmem_aw-1:0] pmem_a_n;

   logic [xmem_aw-1:0] fetch_base;
   logic [cnt_w-1:0]   fetch_len, xl_c;

   assign xl_c = cnt_w'(x_len_q);

   // State, counters, latched tile descriptor and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         rd_cnt   <= '0;
         wr_cnt   <= '0;
         w_base_q <= '0;
         x_base_q <= '0;
         x_len_q  <= '0;
         p_base_q <= '0;
         xmem_cen <= 1'b1;
         xmem_a   <= '0;
         l0_wr    <= 1'b0;
         l0_rd    <= 1'b0;
         load     <= 1'b0;
         execute  <= 1'b0;
         mode     <= 1'b0;
         ofifo_rd <= 1'b0;
         pmem_cen <= 1'b1;
         pmem_wen <= 1'b1;
         pmem_a   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         rd_cnt   <= rd_cnt_n;
         wr_cnt   <= wr_cnt_n;
         w_base_q <= w_base_n;
         x_base_q <= x_base_n;
         x_len_q  <= x_len_n;
         p_base_q <= p_base_n;
         xmem_cen <= xmem_cen_n;
         xmem_a   <= xmem_a_n;
         l0_wr    <= l0_wr_n;
         l0_rd    <= l0_rd_n;
         load     <= load_n;
         execute  <= execute_n;
         mode     <= mode_n;
         ofifo_rd <= ofifo_rd_n;
         pmem_cen <= pmem_cen_n;
         pmem_wen <= pmem_wen_n;
         pmem_a   <= pmem_a_n;
         busy     <= busy_n;
         done     <= done_n;
      end
   end

   // Next-state and next-output decode; outputs become visible one edge later.
   always_comb begin
      state_n    = state;
      rd_cnt_n   = rd_cnt;
      wr_cnt_n   = wr_cnt;
      w_base_n   = w_base_q;
      x_base_n   = x_base_q;
      x_len_n    = x_len_q;
      p_base_n   = p_base_q;
      xmem_cen_n = 1'b1;
      xmem_a_n   = xmem_a;
      // XMEM data arrives one cycle after the request, so the L0 write trails it.
      l0_wr_n    = ~xmem_cen;
      l0_rd_n    = 1'b0;
      load_n     = 1'b0;
      execute_n  = 1'b0;
      mode_n     = mode;
      ofifo_rd_n = 1'b0;
      pmem_cen_n = 1'b1;
      pmem_wen_n = 1'b1;
      pmem_a_n   = pmem_a;
      fetch_base = (state == XFETCH) ? x_base_q : w_base_q;
      fetch_len  = (state == XFETCH) ? xl_c : row_c;

      case (state)
         IDLE: begin
            if (start) begin
               w_base_n = w_base;
               x_base_n = x_base;
               x_len_n  = x_len;
               p_base_n = p_base;
               mode_n   = mode_i;
               rd_cnt_n = '0;
               wr_cnt_n = '0;
               state_n  = WFETCH;
            end
         end
         WFETCH, XFETCH: begin
            // A stalled L0 blocks new requests; an in-flight read still lands.
            if (l0_ready && (rd_cnt != fetch_len)) begin
               xmem_cen_n = 1'b0;
               xmem_a_n   = fetch_base + xmem_aw'(rd_cnt);
               rd_cnt_n   = rd_cnt + cnt_w'(1);
            end
            if (l0_wr) begin
               wr_cnt_n = wr_cnt + cnt_w'(1);
               if (wr_cnt == fetch_len - cnt_w'(1)) begin
                  // Last vector written: first push/exec strobe goes out now.
                  rd_cnt_n = cnt_w'(1);
                  wr_cnt_n = '0;
                  l0_rd_n  = 1'b1;
                  if (state == WFETCH) begin
                     state_n = WPUSH;
                     load_n  = 1'b1;
                  end else begin
                     state_n   = EXEC;
                     execute_n = 1'b1;
                  end
               end
            end
         end
         WPUSH: begin
            if (rd_cnt != row_c) begin
               l0_rd_n  = 1'b1;
               load_n   = 1'b1;
               rd_cnt_n = rd_cnt + cnt_w'(1);
            end else begin
               rd_cnt_n = '0;
               state_n  = (x_len_q == '0) ? FIN : XFETCH;
            end
         end
         EXEC: begin
            if (rd_cnt != xl_c) begin
               l0_rd_n   = 1'b1;
               execute_n = 1'b1;
               rd_cnt_n  = rd_cnt + cnt_w'(1);
            end else begin
               rd_cnt_n = '0;
               wr_cnt_n = '0;
               state_n  = DRAIN;
            end
         end
         DRAIN: begin
            // A read cycle is always followed by its write cycle, which
            // limits OFIFO reads to one every two cycles.
            if (ofifo_rd) begin
               pmem_cen_n = 1'b0;
               pmem_wen_n = 1'b0;
               pmem_a_n   = p_base_q + pmem_aw'(wr_cnt);
               wr_cnt_n   = wr_cnt + cnt_w'(1);
            end else if (ofifo_valid && (rd_cnt != xl_c)) begin
               ofifo_rd_n = 1'b1;
               rd_cnt_n   = rd_cnt + cnt_w'(1);
            end
            if (!pmem_cen && (wr_cnt == xl_c)) begin
               state_n = FIN;
            end
         end
         FIN: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      busy_n = (state_n != IDLE);
      done_n = (state_n == FIN);
   end

endmodule

// File: tb/tb_core_seq.sv
// tb_core_seq: scoreboard bench for core_seq. Expected XMEM and PMEM addresses
// are queued when a tile is launched and consumed as the DUT issues accesses.
module tb_core_seq;

   localparam int row = 8;

   logic       clk = 1'b0;
   logic       reset, start, mode_i, l0_ready, ofifo_valid;
   logic [7:0] w_base, x_base, x_len;
   logic [8:0] p_base;
   logic       xmem_cen, l0_wr, l0_rd, load, execute, mode, ofifo_rd;
   logic       pmem_cen, pmem_wen, busy, done;
   logic [7:0] xmem_a;
   logic [8:0] pmem_a;

   core_seq dut (
      .clk(clk), .reset(reset), .start(start), .mode_i(mode_i),
      .w_base(w_base), .x_base(x_base), .x_len(x_len), .p_base(p_base),
      .l0_ready(l0_ready), .ofifo_valid(ofifo_valid),
      .xmem_cen(xmem_cen), .xmem_a(xmem_a), .l0_wr(l0_wr), .l0_rd(l0_rd),
      .load(load), .execute(execute), .mode(mode), .ofifo_rd(ofifo_rd),
      .pmem_cen(pmem_cen), .pmem_wen(pmem_wen), .pmem_a(pmem_a),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   logic [7:0] xq[$];
   logic [8:0] pq[$];
   logic [7:0] exp_x;
   logic [8:0] exp_p;
   int checks = 0;
   int errors = 0;
   int rd_seen, wr_seen, l0rd_seen, load_seen, exec_seen, ofrd_seen, pm_seen, done_seen;
   int cyc = 0;
   int last_load_cyc = 0;
   int done_cyc = 0;
   logic prev_cen = 1'b1;
   logic prev_ofrd = 1'b0;
   logic ready_at_edge = 1'b1;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      ready_at_edge <= l0_ready;
   end

   // Output monitor: consumes the scoreboard and checks per-cycle protocol rules.
   always @(negedge clk) begin
      if (xmem_cen === 1'b0) begin
         rd_seen++;
         checks++;
         if (xq.size() == 0) begin
            errors++;
            $display("FAIL xmem_read: unexpected read at %h, no read expected", xmem_a);
         end else begin
            exp_x = xq.pop_front();
            if (xmem_a !== exp_x) begin
               errors++;
               $display("FAIL xmem_addr: got %h, expected %h", xmem_a, exp_x);
            end
         end
         checks++;
         if (ready_at_edge !== 1'b1) begin
            errors++;
            $display("FAIL read_stall: read at %h issued while l0_ready was %b", xmem_a, ready_at_edge);
         end
      end
      if (l0_wr === 1'b1) begin
         wr_seen++;
         checks++;
         if (prev_cen !== 1'b0) begin
            errors++;
            $display("FAIL l0_wr_latency: previous xmem_cen %b, expected 0", prev_cen);
         end
      end
      if (l0_rd === 1'b1) begin
         l0rd_seen++;
         checks++;
         if (l0_wr !== 1'b0) begin
            errors++;
            $display("FAIL l0_overlap: l0_wr %b with l0_rd high, expected 0", l0_wr);
         end
      end
      if (load === 1'b1) begin
         load_seen++;
         last_load_cyc = cyc;
      end
      if (execute === 1'b1) exec_seen++;
      if (ofifo_rd === 1'b1) ofrd_seen++;
      if (pmem_cen === 1'b0) begin
         pm_seen++;
         checks++;
         if (pq.size() == 0) begin
            errors++;
            $display("FAIL pmem_write: unexpected write at %h, no write expected", pmem_a);
         end else begin
            exp_p = pq.pop_front();
            if (pmem_a !== exp_p) begin
               errors++;
               $display("FAIL pmem_addr: got %h, expected %h", pmem_a, exp_p);
            end
         end
         checks++;
         if (pmem_wen !== 1'b0) begin
            errors++;
            $display("FAIL pmem_wen: got %b, expected 0", pmem_wen);
         end
         checks++;
         if (prev_ofrd !== 1'b1) begin
            errors++;
            $display("FAIL pmem_latency: previous ofifo_rd %b, expected 1", prev_ofrd);
         end
      end
      if (done === 1'b1) begin
         done_seen++;
         done_cyc = cyc;
      end
      prev_cen = xmem_cen;
      prev_ofrd = ofifo_rd;
   end

   // Queue expectations, clear counters, pulse start, then scramble the
   // descriptor inputs so only latched values can produce the right addresses.
   task automatic start_tile(input logic [7:0] wb, input logic [7:0] xb, input logic [7:0] xl,
                             input logic [8:0] pb, input logic md);
      logic [7:0] a;
      logic [8:0] p;
      xq.delete();
      pq.delete();
      for (int k = 0; k < row; k++) begin
         a = wb + 8'(k);
         xq.push_back(a);
      end
      for (int k = 0; k < int'(xl); k++) begin
         a = xb + 8'(k);
         xq.push_back(a);
         p = pb + 9'(k);
         pq.push_back(p);
      end
      rd_seen = 0; wr_seen = 0; l0rd_seen = 0; load_seen = 0;
      exec_seen = 0; ofrd_seen = 0; pm_seen = 0; done_seen = 0;
      w_base = wb; x_base = xb; x_len = xl; p_base = pb; mode_i = md;
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      w_base = ~wb; x_base = ~xb; x_len = ~xl; p_base = ~pb; mode_i = ~md;
   endtask

   task automatic wait_done(input bit toggle, output bit ok);
      int n;
      n = 0;
      ok = 1'b0;
      while (n < 3000) begin
         if (toggle) ofifo_valid = ~ofifo_valid;
         @(negedge clk); #1;
         if (done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         n++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; mode_i = 1'b0; l0_ready = 1'b1; ofifo_valid = 1'b1;
      w_base = '0; x_base = '0; x_len = '0; p_base = '0;
      repeat (3) begin @(negedge clk); #1; end
      reset = 1'b0;
      repeat (5) begin @(negedge clk); #1; end
      checks++; if (xmem_cen !== 1'b1) begin errors++; $display("FAIL reset_xmem_cen: got %b, expected 1", xmem_cen); end
      checks++; if (pmem_cen !== 1'b1) begin errors++; $display("FAIL reset_pmem_cen: got %b, expected 1", pmem_cen); end
      checks++; if (pmem_wen !== 1'b1) begin errors++; $display("FAIL reset_pmem_wen: got %b, expected 1", pmem_wen); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
      checks++;
      if ({l0_wr, l0_rd, load, execute, ofifo_rd, mode} !== 6'b0) begin
         errors++;
         $display("FAIL reset_strobes: got %b, expected 000000",
                  {l0_wr, l0_rd, load, execute, ofifo_rd, mode});
      end
      checks++; if (xmem_a !== 8'h00) begin errors++; $display("FAIL reset_xmem_a: got %h, expected 00", xmem_a); end
      checks++; if (pmem_a !== 9'h000) begin errors++; $display("FAIL reset_pmem_a: got %h, expected 000", pmem_a); end
   endtask

   task automatic test_basic();
      bit ok;
      start_tile(8'h00, 8'h10, 8'd4, 9'h020, 1'b1);
      wait_done(1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_done: got timeout, expected done pulse"); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_at_done: got %b, expected 1", busy); end
      @(negedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b, expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b, expected 0", done); end
      checks++; if (rd_seen != 12) begin errors++; $display("FAIL basic_reads: got %0d, expected 12", rd_seen); end
      checks++; if (wr_seen != 12) begin errors++; $display("FAIL basic_l0_wr: got %0d, expected 12", wr_seen); end
      checks++; if (load_seen != 8) begin errors++; $display("FAIL basic_load: got %0d, expected 8", load_seen); end
      checks++; if (l0rd_seen != 12) begin errors++; $display("FAIL basic_l0_rd: got %0d, expected 12", l0rd_seen); end
      checks++; if (exec_seen != 4) begin errors++; $display("FAIL basic_execute: got %0d, expected 4", exec_seen); end
      checks++; if (ofrd_seen != 4) begin errors++; $display("FAIL basic_ofifo_rd: got %0d, expected 4", ofrd_seen); end
      checks++; if (pm_seen != 4) begin errors++; $display("FAIL basic_pmem: got %0d, expected 4", pm_seen); end
      checks++; if (done_seen != 1) begin errors++; $display("FAIL basic_done_count: got %0d, expected 1", done_seen); end
      checks++; if (mode !== 1'b1) begin errors++; $display("FAIL basic_mode: got %b, expected 1", mode); end
   endtask

   task automatic test_stall();
      bit ok;
      int n;
      start_tile(8'h00, 8'h10, 8'd4, 9'h020, 1'b0);
      n = 0;
      while (rd_seen < 3 && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      checks++; if (rd_seen != 3) begin errors++; $display("FAIL stall_reach: got %0d reads, expected 3", rd_seen); end
      l0_ready = 1'b0;
      repeat (3) begin @(negedge clk); #1; end
      checks++; if (rd_seen != 3) begin errors++; $display("FAIL stall_pause: got %0d reads, expected 3", rd_seen); end
      l0_ready = 1'b1;
      wait_done(1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL stall_done: got timeout, expected done pulse"); end
      checks++; if (wr_seen != 12) begin errors++; $display("FAIL stall_l0_wr: got %0d, expected 12", wr_seen); end
      checks++; if (rd_seen != 12) begin errors++; $display("FAIL stall_reads: got %0d, expected 12", rd_seen); end
      checks++; if (pm_seen != 4) begin errors++; $display("FAIL stall_pmem: got %0d, expected 4", pm_seen); end
      checks++; if (mode !== 1'b0) begin errors++; $display("FAIL stall_mode: got %b, expected 0", mode); end
      @(negedge clk); #1;
   endtask

   task automatic test_wrap_zero();
      bit ok;
      start_tile(8'hFE, 8'h00, 8'd0, 9'h000, 1'b0);
      wait_done(1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL zero_done: got timeout, expected done pulse"); end
      @(negedge clk); #1;
      checks++; if (rd_seen != 8) begin errors++; $display("FAIL zero_reads: got %0d, expected 8", rd_seen); end
      checks++; if (wr_seen != 8) begin errors++; $display("FAIL zero_l0_wr: got %0d, expected 8", wr_seen); end
      checks++; if (load_seen != 8) begin errors++; $display("FAIL zero_load: got %0d, expected 8", load_seen); end
      checks++; if (exec_seen != 0) begin errors++; $display("FAIL zero_execute: got %0d, expected 0", exec_seen); end
      checks++; if (ofrd_seen != 0) begin errors++; $display("FAIL zero_ofifo_rd: got %0d, expected 0", ofrd_seen); end
      checks++; if (pm_seen != 0) begin errors++; $display("FAIL zero_pmem: got %0d, expected 0", pm_seen); end
      checks++;
      if (done_cyc <= last_load_cyc || done_cyc - last_load_cyc > 3) begin
         errors++;
         $display("FAIL zero_done_gap: got %0d cycles after last load, expected 1..3", done_cyc - last_load_cyc);
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_after: got %b, expected 0", busy); end
   endtask

   task automatic test_pmem_wrap();
      bit ok;
      ofifo_valid = 1'b0;
      start_tile(8'h80, 8'h40, 8'd3, 9'h1FE, 1'b1);
      wait_done(1'b1, ok);
      ofifo_valid = 1'b1;
      checks++; if (!ok) begin errors++; $display("FAIL wrap_done: got timeout, expected done pulse"); end
      checks++; if (pm_seen != 3) begin errors++; $display("FAIL wrap_pmem: got %0d, expected 3", pm_seen); end
      checks++; if (ofrd_seen != 3) begin errors++; $display("FAIL wrap_ofifo_rd: got %0d, expected 3", ofrd_seen); end
      checks++; if (exec_seen != 3) begin errors++; $display("FAIL wrap_execute: got %0d, expected 3", exec_seen); end
      checks++; if (pq.size() != 0) begin errors++; $display("FAIL wrap_pending: got %0d writes missing, expected 0", pq.size()); end
      @(negedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int n;
      int rd_before;
      start_tile(8'h20, 8'h30, 8'd8, 9'h100, 1'b1);
      n = 0;
      while (exec_seen < 1 && n < 500) begin
         @(negedge clk); #1;
         n++;
      end
      checks++; if (exec_seen < 1) begin errors++; $display("FAIL mid_exec_reach: got %0d execute cycles, expected 1", exec_seen); end
      mode_i = 1'b0; w_base = 8'h55; x_len = 8'd2;
      start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b, expected 1", busy); end
      checks++; if (mode !== 1'b1) begin errors++; $display("FAIL mid_mode_hold: got %b, expected 1", mode); end
      checks++; if (execute !== 1'b1) begin errors++; $display("FAIL mid_execute: got %b, expected 1", execute); end
      @(negedge clk); #1;
      reset = 1'b1;
      @(negedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b, expected 0", busy); end
      checks++; if (execute !== 1'b0) begin errors++; $display("FAIL mid_reset_execute: got %b, expected 0", execute); end
      checks++; if (l0_rd !== 1'b0) begin errors++; $display("FAIL mid_reset_l0_rd: got %b, expected 0", l0_rd); end
      checks++; if (xmem_cen !== 1'b1) begin errors++; $display("FAIL mid_reset_xmem_cen: got %b, expected 1", xmem_cen); end
      checks++; if (mode !== 1'b0) begin errors++; $display("FAIL mid_reset_mode: got %b, expected 0", mode); end
      reset = 1'b0;
      pq.delete();
      rd_before = rd_seen;
      repeat (10) begin @(negedge clk); #1; end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_idle_busy: got %b, expected 0", busy); end
      checks++; if (rd_seen != rd_before) begin errors++; $display("FAIL mid_idle_reads: got %0d, expected %0d", rd_seen, rd_before); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_wrap_zero();
      test_pmem_wrap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
